uart_tx_fifo: RTL

//  Parametrised async serial transmitter with an on-chip TX FIFO. Supports runtime-fixed frame

---
 rtl/uart_tx_fifo_pkg.sv | 23 ++
 rtl/uart_tx_fifo_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, FSM states, baud divisors.
package uart_tx_fifo_pkg;

  // Parity selection values for the PARITY parameter
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Common baud divisors for a 50 MHz system clock
  localparam int unsigned BAUDDIV_9600   = 5208;
  localparam int unsigned BAUDDIV_19200  = 2604;
  localparam int unsigned BAUDDIV_115200 = 434;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised; pointers wrap naturally.
module uart_tx_fifo_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_c;
  logic             do_pop_c;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rdata_o   = mem_q[rd_q];
  assign do_push_c = push_i & ~full_o;
  assign do_pop_c  = pop_i & ~empty_o;

  // Pointer and occupancy update; simultaneous push and pop keeps the count
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push_c) wr_d = wr_q + PTR_W'(1);
    if (do_pop_c)  rd_d = rd_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Async serial transmitter with a TX FIFO; frames leave back-to-back while bytes are queued.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned BAUDDIV    = BAUDDIV_9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 busy
);

  localparam int unsigned CNT_W  = $clog2(BAUDDIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  // Reject frame formats the serialiser cannot produce
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY > 2 ||
      BAUDDIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tick_c;
  logic                 last_data_c;
  logic                 last_stop_c;
  logic                 pop_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [FCNT_W-1:0]    fifo_count;

  uart_tx_fifo_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (start),
    .pop_i   (pop_c),
    .wdata_i (data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tick_c      = (baud_q == CNT_W'(BAUDDIV - 1));
  assign last_data_c = (bit_q == BIT_W'(DATA_BITS - 1));
  assign last_stop_c = (bit_q == BIT_W'(STOP_BITS - 1));
  assign tx          = tx_q;
  assign ready       = ~fifo_full;
  assign busy        = (state_q != ST_IDLE) | (fifo_count != '0);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: one bit period per tick, chaining straight into the next frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (tick_c) state_d = ST_DATA;
      ST_DATA:   if (tick_c && last_data_c)
                   state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick_c) state_d = ST_STOP;
      ST_STOP:   if (tick_c && last_stop_c)
                   state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop strobe and the line level for the current bit
  always_comb begin
    pop_c = 1'b0;
    tx_d  = 1'b1;
    case (state_q)
      ST_IDLE:   pop_c = ~fifo_empty;
      ST_START:  tx_d  = 1'b0;
      ST_DATA:   tx_d  = shift_q[0];
      ST_PARITY: tx_d  = par_q;
      ST_STOP:   pop_c = tick_c & last_stop_c & ~fifo_empty;
      default:   tx_d  = 1'b1;
    endcase
  end

  // Datapath next values: baud counter, bit counter, shifter and parity capture
  always_comb begin
    baud_d  = (state_q == ST_IDLE || tick_c) ? '0 : baud_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_d != state_q) bit_d = '0;
    else if (tick_c)        bit_d = bit_q + BIT_W'(1);
    if (pop_c) begin
      shift_d = fifo_rdata;
      par_d   = (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end else if (state_q == ST_DATA && tick_c) begin
      shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
    end
  end

  // Datapath and line registers; the line idles high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule
